// File: rtl/mult16_share_sched.sv
// Shares one external 16x16 compressor tree among NUM_REQ requesters, with credit-protected result FIFO.
// Define MULT16_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mult16_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int COMP_LAT   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][15:0] req_a,
  input  logic [NUM_REQ-1:0][15:0] req_b,
  output logic [255:0]             comp_pp,
  input  logic [31:0]              comp_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ID_W-1:0]          res_id,
  output logic [31:0]              res_data
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  logic [255:0]                 comp_pp_q, pp_d;
  logic [COMP_LAT:0]            vld_pipe_q;
  logic [COMP_LAT:0][ID_W-1:0]  id_pipe_q;
  logic [CNT_W-1:0]             inflight_q, cnt_q;
  logic [AW-1:0]                wr_q, rd_q;
  logic [ID_W+31:0]             mem_q [FIFO_DEPTH];

  logic            can_issue, found_c, acc, push, pop;
  logic [ID_W-1:0] gnt_id_c, cand;
  logic [15:0]     a_sel, b_sel;

  // Credits cover both the compressor pipeline and the FIFO, so a push always has room.
  assign can_issue = ({1'b0, inflight_q} + {1'b0, cnt_q}) < (CNT_W+1)'(FIFO_DEPTH);

`ifndef MULT16_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0] ptr_q;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return ID_W'(s);
  endfunction
`endif

  always_comb begin
    cand     = '0;
    gnt_id_c = '0;
    found_c  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MULT16_SCHED_FIXED_PRIO_EN
      cand = ID_W'(k);
`else
      cand = rr_idx(ptr_q, k);
`endif
      if (!found_c && req_valid[cand]) begin
        found_c  = 1'b1;
        gnt_id_c = cand;
      end
    end
  end

  assign req_ready = (found_c && can_issue && rst_n) ? (NUM_REQ'(1) << gnt_id_c) : '0;
  assign acc       = |(req_valid & req_ready);
  assign a_sel     = req_a[gnt_id_c];
  assign b_sel     = req_b[gnt_id_c];

  // Bit 16*i+j carries a[j]&b[i] (weight i+j); zero when nothing is accepted.
  for (genvar i = 0; i < 16; i++) begin : g_row
    for (genvar j = 0; j < 16; j++) begin : g_col
      assign pp_d[16*i+j] = acc & a_sel[j] & b_sel[i];
    end
  end

  assign push = vld_pipe_q[COMP_LAT];
  assign pop  = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      comp_pp_q  <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
`ifndef MULT16_SCHED_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      comp_pp_q  <= pp_d;
      // Stage 0 lines up with comp_pp; stage COMP_LAT lines up with comp_out.
      vld_pipe_q <= {vld_pipe_q[COMP_LAT-1:0], acc};
      id_pipe_q  <= {id_pipe_q[COMP_LAT-1:0], gnt_id_c};
      case ({acc, push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
`ifndef MULT16_SCHED_FIXED_PRIO_EN
      if (acc) ptr_q <= (int'(gnt_id_c) == NUM_REQ - 1) ? '0 : gnt_id_c + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_q] <= {id_pipe_q[COMP_LAT], comp_out};
  end

  assign comp_pp   = comp_pp_q;
  assign res_valid = (cnt_q != '0);
  assign res_id    = res_valid ? mem_q[rd_q][ID_W+31:32] : '0;
  assign res_data  = res_valid ? mem_q[rd_q][31:0] : '0;

endmodule

// File: tb/tb_mult16_share_sched.sv
// Scoreboard bench for mult16_share_sched: compressor and arbiter modelled arithmetically, monitor on negedge.
module tb_mult16_share_sched;
  localparam int NR = 4, CL = 1, FD = 4, IW = 2;

  logic                clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0]       req_valid = '0, req_ready;
  logic [NR-1:0][15:0] req_a = '0, req_b = '0;
  logic [255:0]        comp_pp;
  logic [31:0]         comp_out, res_data;
  logic                res_valid, res_ready = 1'b0;
  logic [IW-1:0]       res_id;

  mult16_share_sched #(.NUM_REQ(NR), .COMP_LAT(CL), .FIFO_DEPTH(FD), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .comp_pp(comp_pp), .comp_out(comp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data));

  always #5 clk = ~clk;

  // External compressor: weighted bit sum of the partial products, COMP_LAT registers deep.
  logic [31:0] comp_pipe [CL];
  function automatic logic [31:0] pp_sum(input logic [255:0] pp);
    logic [31:0] s = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (pp[16*i+j]) s += 32'd1 << (i + j);
    return s;
  endfunction
  always @(posedge clk) begin
    comp_pipe[0] <= pp_sum(comp_pp);
    for (int k = 1; k < CL; k++) comp_pipe[k] <= comp_pipe[k-1];
  end
  assign comp_out = comp_pipe[CL-1];

  typedef struct { logic [IW-1:0] id; logic [31:0] prod; int rdy; } exp_t;
  exp_t          q[$];
  int            cyc = 0, ptr_m = 0, n_cmp = 0, n_err = 0;
  logic [NR-1:0] eg, acc_last = '0;
  logic          exp_v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: inputs and outputs are stable here; the handshakes seen now happen at the next posedge.
  always @(negedge clk) begin
    eg = '0;
    if (rst_n && q.size() < FD) begin
      for (int k = 0; k < NR; k++) begin
        int ix;
`ifdef MULT16_SCHED_FIXED_PRIO_EN
        ix = k;
`else
        ix = (ptr_m + k) % NR;
`endif
        if (req_valid[ix] && eg == '0) eg[ix] = 1'b1;
      end
    end
    chk("req_ready", req_ready, eg);
    exp_v = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("res_valid", res_valid, exp_v);
    if (res_valid && exp_v) begin
      chk("res_id", res_id, q[0].id);
      chk("res_data", res_data, q[0].prod);
    end
    acc_last = req_valid & req_ready;
    if (!rst_n) begin
      q.delete();
      ptr_m = 0;
    end else begin
      if (res_valid && res_ready && q.size() > 0) void'(q.pop_front());
      for (int i = 0; i < NR; i++)
        if (acc_last[i]) begin
          q.push_back('{IW'(i), 32'(req_a[i]) * 32'(req_b[i]), cyc + CL + 2});
          ptr_m = (i + 1) % NR;
        end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b);
    req_valid = '0;
    req_valid[id] = 1'b1; req_a[id] = a; req_b[id] = b;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (acc_last[id]) break;
    end
    chk("issue_grant", acc_last[id], 1'b1);
    req_valid = '0;
  endtask

  task automatic drain();
    req_valid = '0; res_ready = 1'b1;
    for (int n = 0; n < 100 && q.size() != 0; n++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  // Keep operands stable while waiting; refresh after a grant.
  task automatic refresh_granted();
    for (int i = 0; i < NR; i++)
      if (acc_last[i]) begin req_a[i] = 16'($urandom); req_b[i] = 16'($urandom); end
  endtask

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_comp_pp", comp_pp, 256'h0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    tick();

    res_ready = 1'b1;
    issue(0, 16'h1234, 16'h5678);
    repeat (4) tick();
    issue(1, 16'hFFFF, 16'hFFFF);
    issue(2, 16'h0000, 16'hBEEF);
    issue(3, 16'h8000, 16'h0002);
    drain();

    // All requesters continuously valid, consumer keeping pace.
    for (int i = 0; i < NR; i++) begin req_a[i] = 16'($urandom); req_b[i] = 16'($urandom); end
    req_valid = '1; res_ready = 1'b1;
    repeat (12) begin tick(); refresh_granted(); end

    // Backpressure: credits run out, then one pop frees exactly one.
    res_ready = 1'b0;
    repeat (10) begin tick(); refresh_granted(); end
    res_ready = 1'b1; tick(); refresh_granted();
    res_ready = 1'b0;
    repeat (6) begin tick(); refresh_granted(); end
    drain();

    // Reset with one result buffered and two in flight.
    res_ready = 1'b0;
    issue(0, 16'h0101, 16'h0202);
    repeat (3) tick();
    issue(1, 16'h1111, 16'h0003);
    issue(2, 16'h2222, 16'h0005);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (CL + 2) tick();
    res_ready = 1'b1;
    issue(3, 16'hABCD, 16'h1234);
    drain();

    // Requesters 0 and 2 contend, then 0 drops out.
    req_valid = 4'b0101; res_ready = 1'b1;
    repeat (6) begin tick(); refresh_granted(); end
    req_valid[0] = 1'b0;
    repeat (3) begin tick(); refresh_granted(); end
    drain();

    // Randomized traffic with random backpressure and valid drops.
    repeat (300) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || acc_last[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 5))
            0:       begin req_a[i] = 16'hFFFF; req_b[i] = 16'hFFFF; end
            1:       begin req_a[i] = 16'h0000; req_b[i] = 16'($urandom); end
            default: begin req_a[i] = 16'($urandom); req_b[i] = 16'($urandom); end
          endcase
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      tick();
    end
    drain();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
